baopoco_status_collect: RTL and testbench



---
 rtl/baopoco_status_collect.sv | 133 +++++++++++++
 tb/tb_baopoco_status_collect.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/baopoco_status_collect.sv
// Status collector feeding the baopoco status register: sticky overflow flags,
// sync/overflow counters, link state. Optional heartbeat: BAOPOCO_STATUS_HEARTBEAT_EN.
module baopoco_status_collect #(
  parameter logic [31:0] SYNC_PERIOD = 32'd65536,
  parameter int          HB_LOG2     = 26
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        sync_in,
  input  logic        adc0_ovf,
  input  logic        adc1_ovf,
  input  logic        fft_ovf,
  input  logic        tx_ovf,
  input  logic        link_up,
  input  logic        clear_req,
  output logic [31:0] status_word
);

  // state | meaning
  // CLEAR | counters and flags zeroed, one cycle
  // WAIT  | armed, waiting for first sync pulse
  // RUN   | measuring; bit 1 of the encoding is the run flag
  localparam logic [1:0] S_CLEAR = 2'b00;
  localparam logic [1:0] S_WAIT  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;

  localparam logic [31:0] L_PERIOD_M1 = SYNC_PERIOD - 32'd1;

  logic [1:0]  r_state;
  logic        r_clear_req_d;
  logic        r_link_up_q;
  logic [6:0]  r_sync_cnt;
  logic [31:0] r_period_cnt;
  logic        r_sync_err;
  logic        r_adc0_stk;
  logic        r_adc1_stk;
  logic        r_fft_stk;
  logic        r_tx_stk;
  logic [15:0] r_ovf_cnt;
  logic        r_ovf_sat;

  logic w_clear_edge;
  logic w_zero;
  logic w_any_ovf;
  logic w_heartbeat;

  assign w_clear_edge = clear_req & ~r_clear_req_d;
  assign w_zero       = w_clear_edge | (r_state == S_CLEAR);
  assign w_any_ovf    = adc0_ovf | adc1_ovf | fft_ovf | tx_ovf;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state       <= S_CLEAR;
      r_clear_req_d <= 1'b0;
      r_link_up_q   <= 1'b0;
    end else begin
      r_clear_req_d <= clear_req;
      r_link_up_q   <= link_up;
      if (w_clear_edge) begin
        r_state <= S_CLEAR;
      end else begin
        case (r_state)
          S_CLEAR: r_state <= S_WAIT;
          S_WAIT:  if (sync_in) r_state <= S_RUN;
          S_RUN:   r_state <= S_RUN;
          default: r_state <= S_CLEAR;
        endcase
      end
    end
  end

  // Clear edge wins over any event sampled on the same cycle.
  always_ff @(posedge user_clk) begin
    if (user_rst || w_zero) begin
      r_sync_cnt   <= 7'd0;
      r_period_cnt <= 32'd0;
      r_sync_err   <= 1'b0;
      r_adc0_stk   <= 1'b0;
      r_adc1_stk   <= 1'b0;
      r_fft_stk    <= 1'b0;
      r_tx_stk     <= 1'b0;
      r_ovf_cnt    <= 16'd0;
      r_ovf_sat    <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (sync_in) begin
        r_sync_cnt   <= 7'd1;
        r_period_cnt <= 32'd0;
      end
    end else if (r_state == S_RUN) begin
      if (sync_in) begin
        r_sync_cnt   <= r_sync_cnt + 7'd1;
        r_period_cnt <= 32'd0;
        if (r_period_cnt != L_PERIOD_M1) r_sync_err <= 1'b1;
      end else if (r_period_cnt != 32'hFFFF_FFFF) begin
        r_period_cnt <= r_period_cnt + 32'd1;
      end
      if (adc0_ovf) r_adc0_stk <= 1'b1;
      if (adc1_ovf) r_adc1_stk <= 1'b1;
      if (fft_ovf)  r_fft_stk  <= 1'b1;
      if (tx_ovf)   r_tx_stk   <= 1'b1;
      if (w_any_ovf && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
        if (r_ovf_cnt == 16'hFFFE) r_ovf_sat <= 1'b1;
      end
    end
  end

`ifdef BAOPOCO_STATUS_HEARTBEAT_EN
  // Free-running; only reset stops it, so software sees clk liveness across clears.
  logic [HB_LOG2-1:0] r_hb_cnt;
  logic               r_heartbeat;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_hb_cnt    <= '0;
      r_heartbeat <= 1'b0;
    end else begin
      r_hb_cnt <= r_hb_cnt + 1'b1;
      if (&r_hb_cnt) r_heartbeat <= ~r_heartbeat;
    end
  end

  assign w_heartbeat = r_heartbeat;
`else
  // Always false; referencing HB_LOG2 keeps the parameter meaningful in this build.
  assign w_heartbeat = (HB_LOG2 < 0);
`endif

  assign status_word = {r_state[1], r_sync_cnt, r_adc0_stk, r_adc1_stk, r_fft_stk,
                        r_tx_stk, r_sync_err, r_link_up_q, w_heartbeat, r_ovf_sat,
                        r_ovf_cnt};

endmodule

// File: tb/tb_baopoco_status_collect.sv
// Directed self-checking bench for baopoco_status_collect (SYNC_PERIOD=16, HB_LOG2=4).
module tb_baopoco_status_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_in, adc0, adc1, fft, tx, link, clr;
  logic [31:0] sw;
  int          checks   = 0;
  int          failures = 0;

  baopoco_status_collect #(.SYNC_PERIOD(32'd16), .HB_LOG2(4)) dut (
    .user_clk(clk), .user_rst(rst), .sync_in(sync_in), .adc0_ovf(adc0),
    .adc1_ovf(adc1), .fft_ovf(fft), .tx_ovf(tx), .link_up(link),
    .clear_req(clr), .status_word(sw)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Heartbeat bit is masked out of word checks; it is checked on its own.
  task automatic chk_sw(input string tag, input logic [31:0] exp);
    chk(tag, sw & 32'hFFFD_FFFF, exp);
  endtask

  task automatic sync_pulse();
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
  endtask

  initial begin
    logic hb_prev;
    logic hb_seen;
    rst = 1'b1; sync_in = 0; adc0 = 0; adc1 = 0; fft = 0; tx = 0; link = 0; clr = 0;
    tick(3);
    chk("reset_word", sw, 32'h0000_0000);
    rst = 1'b0;
    tick(1);
    chk_sw("clear_after_reset", 32'h0000_0000);
    tick(1);
    chk_sw("wait_sync_idle", 32'h0000_0000);
`ifndef BAOPOCO_STATUS_HEARTBEAT_EN
    chk("hb_off_bit17", {31'd0, sw[17]}, 32'd0);
`endif

    sync_pulse();
    chk_sw("arm_first_sync", 32'h8100_0000);
    for (int i = 2; i <= 130; i++) begin
      tick(15);
      sync_pulse();
      if (i == 127) chk_sw("sync_cnt_127", 32'hFF00_0000);
      if (i == 128) chk_sw("sync_cnt_wrap", 32'h8000_0000);
    end
    chk_sw("sync_130", 32'h8200_0000);

    tick(14);
    sync_pulse();
    chk_sw("period_err", 32'h8308_0000);
    tick(15);
    sync_pulse();
    chk_sw("period_err_sticky", 32'h8408_0000);

    link = 1'b1;
    tick(1);
    chk_sw("link_up", 32'h840C_0000);
    link = 1'b0;
    tick(1);
    chk_sw("link_not_sticky", 32'h8408_0000);

    adc0 = 1'b1; fft = 1'b1;
    tick(5);
    adc0 = 1'b0; fft = 1'b0;
    chk_sw("ovf_5", 32'h84A8_0005);
    tx = 1'b1;
    tick(70000);
    tx = 1'b0;
    chk_sw("ovf_sat", 32'h84B9_FFFF);

    clr = 1'b1; sync_in = 1'b1; adc1 = 1'b1;
    tick(1);
    sync_in = 1'b0; adc1 = 1'b0;
    chk_sw("clear_priority", 32'h0000_0000);
    tick(1);
    chk_sw("clear_to_wait", 32'h0000_0000);
    adc0 = 1'b1;
    tick(3);
    adc0 = 1'b0;
    chk_sw("wait_ignores_ovf", 32'h0000_0000);
    sync_pulse();
    chk_sw("rearm_held_clear", 32'h8100_0000);
    tick(10);
    chk_sw("held_clear_no_reclear", 32'h8100_0000);
    clr = 1'b0;
    tick(1);
    clr = 1'b1;
    tick(1);
    chk_sw("second_clear", 32'h0000_0000);
    clr = 1'b0;
    tick(1);

    sync_pulse();
    adc1 = 1'b1;
    tick(1);
    adc1 = 1'b0;
    chk_sw("adc1_run", 32'h8140_0001);
    link = 1'b1; rst = 1'b1;
    tick(2);
    chk_sw("reset_mid_run", 32'h0000_0000);
    rst = 1'b0;
    tick(1);
    chk_sw("link_after_reset", 32'h0004_0000);
    link = 1'b0;
    tick(1);

`ifdef BAOPOCO_STATUS_HEARTBEAT_EN
    hb_prev = sw[17];
    hb_seen = 1'b0;
    for (int i = 0; i < 20 && !hb_seen; i++) begin
      tick(1);
      if (sw[17] !== hb_prev) hb_seen = 1'b1;
    end
    chk("hb_toggle_seen", {31'd0, hb_seen}, 32'd1);
    hb_prev = sw[17];
    tick(8);
    chk("hb_hold", {31'd0, sw[17]}, {31'd0, hb_prev});
    clr = 1'b1;
    tick(8);
    chk("hb_toggle_across_clear", {31'd0, sw[17]}, {31'd0, ~hb_prev});
    clr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
